// File: rtl/apb_uart_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : apb_uart_arbiter_if
//  Brief   : APB master-side bundle between the core arbiter and the UART
//            slave. The master modport drives the request phase; the slave
//            modport returns read data and PREADY.
//  Rev     : 1.0  initial release
// ============================================================================
interface apb_uart_arbiter_if #(
    parameter int BUS_WIDTH = 16
);
    logic [1:0]           M_PADDR;
    logic                 M_PWRITE;
    logic                 M_PSELx;
    logic                 M_PENABLE;
    logic [BUS_WIDTH-1:0] M_PWDATA;
    logic [BUS_WIDTH-1:0] M_PRDATA;
    logic                 M_PREADY;

    modport master (
        output M_PADDR,
        output M_PWRITE,
        output M_PSELx,
        output M_PENABLE,
        output M_PWDATA,
        input  M_PRDATA,
        input  M_PREADY
    );

    modport slave (
        input  M_PADDR,
        input  M_PWRITE,
        input  M_PSELx,
        input  M_PENABLE,
        input  M_PWDATA,
        output M_PRDATA,
        output M_PREADY
    );
endinterface
`default_nettype wire

// File: rtl/apb_uart_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : apb_uart_arbiter
//  Brief   : Round-robin arbiter sharing one APB UART slave among NUM_REQ
//            cores. Optional per-core lock keeps ownership across transfers;
//            a watchdog bounds the PREADY wait. All outputs are registered.
//  Rev     : 1.0  initial release
// ============================================================================
module apb_uart_arbiter #(
    parameter int BUS_WIDTH = 16,
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 1023
) (
    input  wire logic                           clk,
    input  wire logic                           reset,      // active low, async
    input  wire logic [NUM_REQ-1:0]             req_valid,
    input  wire logic [NUM_REQ-1:0]             req_write,
    input  wire logic [NUM_REQ-1:0]             req_lock,
    input  wire logic [NUM_REQ*2-1:0]           req_addr,
    input  wire logic [NUM_REQ*BUS_WIDTH-1:0]   req_wdata,
    output logic      [NUM_REQ-1:0]             req_ready,
    output logic      [NUM_REQ-1:0]             req_err,
    output logic      [BUS_WIDTH-1:0]           rsp_rdata,
    output logic      [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                                busy,
    apb_uart_arbiter_if.master                  apb
);

    localparam int              ID_W       = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] C_RR_RESET = ID_W'(NUM_REQ - 1);
    localparam logic [15:0]     C_WD_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q,      state_d;
    logic [ID_W-1:0]        rr_ptr_q,     rr_ptr_d;
    logic                   lock_valid_q, lock_valid_d;
    logic [ID_W-1:0]        lock_owner_q, lock_owner_d;
    logic [15:0]            wd_q,         wd_d;
    logic [1:0]             paddr_q,      paddr_d;
    logic                   pwrite_q,     pwrite_d;
    logic [BUS_WIDTH-1:0]   pwdata_q,     pwdata_d;
    logic                   psel_q,       psel_d;
    logic                   penable_q,    penable_d;
    logic [NUM_REQ-1:0]     req_ready_q,  req_ready_d;
    logic [NUM_REQ-1:0]     req_err_q,    req_err_d;
    logic [BUS_WIDTH-1:0]   rsp_rdata_q,  rsp_rdata_d;
    logic [ID_W-1:0]        grant_id_q,   grant_id_d;
    logic                   busy_q,       busy_d;

    logic                   lock_hold;
    logic [NUM_REQ-1:0]     eligible;
    logic                   arb_found;
    logic [ID_W-1:0]        arb_idx;
    logic [ID_W-1:0]        scan_idx;

    // While a live lock exists only its owner may compete for the bus.
    always_comb begin
        lock_hold = lock_valid_q && req_lock[lock_owner_q];
        eligible  = lock_hold ? (req_valid & (NUM_REQ'(1) << lock_owner_q)) : req_valid;
    end

    // Round-robin scan starting one past the last winner.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!arb_found && eligible[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = scan_idx;
            end
        end
    end

    // Next-state and next-output computation for the APB sequencer.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        wd_d         = wd_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        grant_id_d   = grant_id_q;
        req_ready_d  = '0;
        req_err_d    = '0;

        case (state_q)
            S_IDLE: begin
                // A lock whose owner stopped asking for it is dropped here,
                // and the same cycle arbitrates normally.
                if (lock_valid_q && !req_lock[lock_owner_q]) begin
                    lock_valid_d = 1'b0;
                end
                if (arb_found) begin
                    grant_id_d = arb_idx;
                    rr_ptr_d   = arb_idx;
                    paddr_d    = req_addr[int'(arb_idx)*2 +: 2];
                    pwrite_d   = req_write[arb_idx];
                    pwdata_d   = req_wdata[int'(arb_idx)*BUS_WIDTH +: BUS_WIDTH];
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                wd_d = wd_q + 16'd1;
                // Only a clean 1 counts as ready; Z/X fall to the else path.
                if (apb.M_PREADY == 1'b1) begin
                    rsp_rdata_d             = apb.M_PRDATA;
                    req_ready_d[grant_id_q] = 1'b1;
                    state_d                 = S_DONE;
                end else if ((TIMEOUT != 0) && (wd_q == C_WD_LAST)) begin
                    req_ready_d[grant_id_q] = 1'b1;
                    req_err_d[grant_id_q]   = 1'b1;
                    state_d                 = S_DONE;
                end
            end
            S_DONE: begin
                wd_d         = '0;
                lock_valid_d = req_lock[grant_id_q];
                lock_owner_d = grant_id_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d = (state_d == S_ACCESS);
        busy_d    = (state_d != S_IDLE);
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= C_RR_RESET;
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
            wd_q         <= '0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            req_ready_q  <= '0;
            req_err_q    <= '0;
            rsp_rdata_q  <= '0;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            wd_q         <= wd_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            req_ready_q  <= req_ready_d;
            req_err_q    <= req_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign req_err       = req_err_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign grant_id      = grant_id_q;
    assign busy          = busy_q;
    assign apb.M_PADDR   = paddr_q;
    assign apb.M_PWRITE  = pwrite_q;
    assign apb.M_PSELx   = psel_q;
    assign apb.M_PENABLE = penable_q;
    assign apb.M_PWDATA  = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_apb_uart_arbiter
//  Brief   : Directed self-checking bench for apb_uart_arbiter. Instance A
//            uses the default watchdog, instance B uses TIMEOUT=8.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_apb_uart_arbiter;

    logic        clk;
    logic        reset;

    logic [3:0]  req_valid_a, req_write_a, req_lock_a;
    logic [7:0]  req_addr_a;
    logic [63:0] req_wdata_a;
    logic [3:0]  req_ready_a, req_err_a;
    logic [15:0] rsp_rdata_a;
    logic [1:0]  grant_id_a;
    logic        busy_a;

    logic [3:0]  req_valid_b, req_write_b, req_lock_b;
    logic [7:0]  req_addr_b;
    logic [63:0] req_wdata_b;
    logic [3:0]  req_ready_b, req_err_b;
    logic [15:0] rsp_rdata_b;
    logic [1:0]  grant_id_b;
    logic        busy_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    int grant_log[$];
    int pwdata_log[$];
    int cycle_log[$];

    apb_uart_arbiter_if #(.BUS_WIDTH(16)) apb_a ();
    apb_uart_arbiter_if #(.BUS_WIDTH(16)) apb_b ();

    apb_uart_arbiter #(.BUS_WIDTH(16), .NUM_REQ(4), .TIMEOUT(1023)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid_a),
        .req_write (req_write_a),
        .req_lock  (req_lock_a),
        .req_addr  (req_addr_a),
        .req_wdata (req_wdata_a),
        .req_ready (req_ready_a),
        .req_err   (req_err_a),
        .rsp_rdata (rsp_rdata_a),
        .grant_id  (grant_id_a),
        .busy      (busy_a),
        .apb       (apb_a)
    );

    apb_uart_arbiter #(.BUS_WIDTH(16), .NUM_REQ(4), .TIMEOUT(8)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid_b),
        .req_write (req_write_b),
        .req_lock  (req_lock_b),
        .req_addr  (req_addr_b),
        .req_wdata (req_wdata_b),
        .req_ready (req_ready_b),
        .req_err   (req_err_b),
        .rsp_rdata (rsp_rdata_b),
        .grant_id  (grant_id_b),
        .busy      (busy_b),
        .apb       (apb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Log every SETUP cycle of instance A: owner, write data and cycle.
    always @(negedge clk) begin
        if (apb_a.M_PSELx && !apb_a.M_PENABLE) begin
            grant_log.push_back(int'(grant_id_a));
            pwdata_log.push_back(int'(apb_a.M_PWDATA));
            cycle_log.push_back(cycle);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int i, input logic v, input logic w, input logic l,
                         input logic [1:0] ad, input logic [15:0] wd);
        req_valid_a[i]          = v;
        req_write_a[i]          = w;
        req_lock_a[i]           = l;
        req_addr_a[i*2 +: 2]    = ad;
        req_wdata_a[i*16 +: 16] = wd;
    endtask

    task automatic set_b(input int i, input logic v, input logic w, input logic l,
                         input logic [1:0] ad, input logic [15:0] wd);
        req_valid_b[i]          = v;
        req_write_b[i]          = w;
        req_lock_b[i]           = l;
        req_addr_b[i*2 +: 2]    = ad;
        req_wdata_b[i*16 +: 16] = wd;
    endtask

    task automatic wait_ready_a(input string tag, input int core, input int limit);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!req_ready_a[core] && n < limit);
        check_eq(tag, req_ready_a[core], 1'b1);
    endtask

    task automatic wait_ready_b(input string tag, input int core, input int limit);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!req_ready_b[core] && n < limit);
        check_eq(tag, req_ready_b[core], 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int acc;
        int rdy;
        int ok;

        reset       = 1'b1;
        req_valid_a = '0; req_write_a = '0; req_lock_a = '0; req_addr_a = '0; req_wdata_a = '0;
        req_valid_b = '0; req_write_b = '0; req_lock_b = '0; req_addr_b = '0; req_wdata_b = '0;
        apb_a.M_PREADY = 1'b1; apb_a.M_PRDATA = '0;
        apb_b.M_PREADY = 1'b1; apb_b.M_PRDATA = 16'h5A5A;

        // ---------------- reset state ----------------
        #2 reset = 1'b0;
        tick(); tick();
        check_eq("rst_psel",    apb_a.M_PSELx,   1'b0);
        check_eq("rst_penable", apb_a.M_PENABLE, 1'b0);
        check_eq("rst_busy",    busy_a,          1'b0);
        check_eq("rst_ready",   req_ready_a,     4'h0);
        check_eq("rst_grant",   grant_id_a,      2'd0);
        check_eq("rst_rdata",   rsp_rdata_a,     16'h0);
        reset = 1'b1;

        // ---------------- single write, core 1 ----------------
        set_a(1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0041);
        tick();
        check_eq("sw_setup_psel",    apb_a.M_PSELx,   1'b1);
        check_eq("sw_setup_penable", apb_a.M_PENABLE, 1'b0);
        check_eq("sw_grant",         grant_id_a,      2'd1);
        check_eq("sw_pwdata",        apb_a.M_PWDATA,  16'h0041);
        check_eq("sw_pwrite",        apb_a.M_PWRITE,  1'b1);
        check_eq("sw_paddr",         apb_a.M_PADDR,   2'd0);
        check_eq("sw_busy",          busy_a,          1'b1);
        tick();
        check_eq("sw_access_penable", apb_a.M_PENABLE, 1'b1);
        check_eq("sw_access_ready",   req_ready_a,     4'h0);
        tick();
        check_eq("sw_done_ready", req_ready_a,   4'b0010);
        check_eq("sw_done_err",   req_err_a,     4'h0);
        check_eq("sw_done_psel",  apb_a.M_PSELx, 1'b0);
        set_a(1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        tick();
        check_eq("sw_idle_ready", req_ready_a, 4'h0);
        check_eq("sw_idle_busy",  busy_a,      1'b0);

        // ---------------- round-robin from reset ----------------
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_a(i, 1'b1, 1'b1, 1'b0, 2'd0, 16'(16'h1000 + i));
        grant_log.delete(); pwdata_log.delete(); cycle_log.delete();
        repeat (20) tick();
        req_valid_a = '0;
        tick();
        check_eq("rr_count", grant_log.size(), 5);
        for (int j = 0; j < 5; j++) begin
            check_eq($sformatf("rr_grant%0d", j),
                     (j < grant_log.size()) ? grant_log[j] : 32'hDEAD, j % 4);
            check_eq($sformatf("rr_wdata%0d", j),
                     (j < pwdata_log.size()) ? pwdata_log[j] : 32'hDEAD, 32'h1000 + (j % 4));
        end
        for (int j = 1; j < 5; j++) begin
            check_eq($sformatf("rr_spacing%0d", j),
                     (j < cycle_log.size()) ? (cycle_log[j] - cycle_log[j-1]) : 32'hDEAD, 4);
        end

        // ---------------- backpressure: 20 stalled ACCESS cycles ----------------
        apb_a.M_PREADY = 1'b0;
        set_a(1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h1234);
        tick();
        check_eq("bp_setup_grant", grant_id_a, 2'd1);
        acc = 0; rdy = 0;
        repeat (21) begin
            tick();
            if (apb_a.M_PSELx && apb_a.M_PENABLE) acc++;
            if (req_ready_a != 4'h0) rdy++;
        end
        check_eq("bp_access_cycles", acc, 21);
        check_eq("bp_no_early_ready", rdy, 0);
        apb_a.M_PRDATA = 16'hBEEF;
        apb_a.M_PREADY = 1'b1;
        tick();
        check_eq("bp_done_ready", req_ready_a, 4'b0010);
        check_eq("bp_done_err",   req_err_a,   4'h0);
        check_eq("bp_rdata",      rsp_rdata_a, 16'hBEEF);
        set_a(1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        tick();

        // ---------------- lock: core 2 sends 3 bytes, core 0 waits ----------------
        grant_log.delete(); pwdata_log.delete(); cycle_log.delete();
        set_a(0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0C00);
        set_a(2, 1'b1, 1'b1, 1'b1, 2'd0, 16'h00A0);
        for (int b = 0; b < 3; b++) begin
            wait_ready_a($sformatf("lk_ready2_%0d", b), 2, 20);
            if (b < 2) set_a(2, 1'b1, 1'b1, 1'b1, 2'd0, 16'(16'h00A1 + b));
            else       set_a(2, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        end
        wait_ready_a("lk_ready0", 0, 20);
        set_a(0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        tick();
        check_eq("lk_count", grant_log.size(), 4);
        for (int j = 0; j < 4; j++) begin
            check_eq($sformatf("lk_grant%0d", j),
                     (j < grant_log.size()) ? grant_log[j] : 32'hDEAD, (j < 3) ? 2 : 0);
            check_eq($sformatf("lk_wdata%0d", j),
                     (j < pwdata_log.size()) ? pwdata_log[j] : 32'hDEAD,
                     (j < 3) ? (32'h00A0 + j) : 32'h0C00);
        end

        // ---------------- timeout on instance B (TIMEOUT=8) ----------------
        set_b(1, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0);
        wait_ready_b("to_pre_ready", 1, 20);
        check_eq("to_pre_rdata", rsp_rdata_b, 16'h5A5A);
        set_b(1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        tick();
        // PREADY never reaches 1 here; the arbiter treats 0/Z/X alike.
        apb_b.M_PREADY = 1'b0;
        apb_b.M_PRDATA = 16'h1111;
        set_b(3, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0);
        set_b(0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0);
        tick();
        check_eq("to_grant3", grant_id_b,     2'd3);
        check_eq("to_paddr",  apb_b.M_PADDR,  2'd1);
        check_eq("to_pwrite", apb_b.M_PWRITE, 1'b0);
        acc = 0; rdy = 0;
        repeat (8) begin
            tick();
            if (apb_b.M_PSELx && apb_b.M_PENABLE) acc++;
            if (req_ready_b != 4'h0) rdy++;
        end
        check_eq("to_access_cycles", acc, 8);
        check_eq("to_no_early_ready", rdy, 0);
        tick();
        check_eq("to_ready", req_ready_b, 4'b1000);
        check_eq("to_err",   req_err_b,   4'b1000);
        check_eq("to_rdata_kept", rsp_rdata_b, 16'h5A5A);
        set_b(3, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        apb_b.M_PREADY = 1'b1;
        wait_ready_b("to_next_ready0", 0, 20);
        check_eq("to_next_grant", grant_id_b, 2'd0);
        check_eq("to_next_err",   req_err_b,  4'h0);
        check_eq("to_next_rdata", rsp_rdata_b, 16'h1111);
        set_b(0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        tick();

        // ---------------- async reset during ACCESS ----------------
        apb_a.M_PREADY = 1'b0;
        set_a(2, 1'b1, 1'b1, 1'b0, 2'd0, 16'h00EE);
        tick();
        tick();
        check_eq("ar_in_access", apb_a.M_PENABLE, 1'b1);
        #3 reset = 1'b0;
        #1;
        check_eq("ar_psel",    apb_a.M_PSELx,   1'b0);
        check_eq("ar_penable", apb_a.M_PENABLE, 1'b0);
        check_eq("ar_busy",    busy_a,          1'b0);
        apb_a.M_PREADY = 1'b1;
        set_a(2, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        set_a(0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0D00);
        set_a(3, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0D03);
        tick();
        check_eq("ar_no_ready", req_ready_a, 4'h0);
        reset = 1'b1;
        tick();
        check_eq("ar_first_grant", grant_id_a,    2'd0);
        check_eq("ar_first_psel",  apb_a.M_PSELx, 1'b1);
        wait_ready_a("ar_ready0", 0, 20);
        req_valid_a = '0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_uart_arbiter.md
Name: apb_uart_arbiter

Overview:
- Shares the single APB UART slave among NUM_REQ processor cores through a per-core valid/ready request port.
- Arbitrates requests round-robin, with an optional lock so one core's message bytes are not interleaved with another's.
- Sequences the APB SETUP/ACCESS phases toward the UART and waits on PREADY, which is the UART's backpressure (TX busy / RX ready).
- A watchdog bounds the PREADY wait so a blocked read cannot stall the other cores indefinitely.

Parameters:
- BUS_WIDTH, 16: APB data width.
- NUM_REQ, 4: number of requesters, range 2..8.
- TIMEOUT, 1023: maximum ACCESS cycles to wait for PREADY; 0 disables the watchdog (16-bit counter).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_REQ  per-core request.
- req_write  in  NUM_REQ  per-core 1=write, 0=read.
- req_lock  in  NUM_REQ  per-core request to keep ownership after the current transfer.
- req_addr  in  NUM_REQ*2  flattened 2-bit UART address; slice i = [2i+1:2i]. 0=TX write port, 1=RX read port.
- req_wdata  in  NUM_REQ*BUS_WIDTH  flattened write data; slice i = [BUS_WIDTH*(i+1)-1 : BUS_WIDTH*i].
- req_ready  out  NUM_REQ  one-cycle completion pulse to the granted core.
- req_err  out  NUM_REQ  one-cycle timeout flag, coincident with req_ready.
- rsp_rdata  out  BUS_WIDTH  PRDATA captured on completion; shared by all cores.
- grant_id  out  clog2(NUM_REQ)  index of the current or last owner.
- busy  out  1  high in every state except IDLE.
- M_PADDR  out  2  APB address to the UART.
- M_PWRITE  out  1  APB write strobe.
- M_PSELx  out  1  APB select.
- M_PENABLE  out  1  APB enable.
- M_PWDATA  out  BUS_WIDTH  APB write data.
- M_PRDATA  in  BUS_WIDTH  APB read data.
- M_PREADY  in  1  APB ready; any non-1 value (0/Z/X) is treated as not ready.

Behaviour:
- Reset: all outputs 0 immediately on assertion (asynchronous). Internally: state=IDLE, rr_ptr=NUM_REQ-1, lock_owner invalid, watchdog=0.
- Reset mid-transaction: APB signals drop at once; no req_ready pulse is issued.
- All outputs are registered.
- FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE, arbitration:
  - With no lock held, scan req_valid starting at rr_ptr+1, modulo NUM_REQ; the first set bit wins.
  - With a lock held, only lock_owner is eligible; others wait even if valid.
  - On a winner: latch its addr, write and wdata; set grant_id; set rr_ptr=winner; go to SETUP.
- SETUP: PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latched request. Lasts exactly 1 cycle.
- ACCESS:
  - PSELx=1, PENABLE=1; the watchdog increments each cycle.
  - PREADY==1: capture PRDATA into rsp_rdata (writes capture as well; the value is don't-care to the core), go to DONE with err=0.
  - TIMEOUT!=0 and watchdog==TIMEOUT-1 without PREADY: go to DONE with err=1; rsp_rdata keeps its previous value.
- DONE:
  - PSELx=0, PENABLE=0.
  - req_ready[grant_id]=1 for exactly one cycle, req_err[grant_id]=err; watchdog cleared.
  - Lock update: if req_lock[grant_id] is 1 this cycle, lock_owner=grant_id; else the lock is cleared.
  - Next state IDLE.
- Lock release in IDLE: if lock_owner's req_lock is 0, the lock clears that cycle and normal arbitration applies in the same cycle.
- Requester handshake:
  - Hold req_valid, addr, write, wdata and lock stable until req_ready is seen.
  - Deassert req_valid on the edge after req_ready, or keep it high to issue a new request; it is re-arbitrated normally.
  - Payload changes while a request is pending are ignored after latching.
- Latency: valid seen in IDLE at cycle T gives SETUP at T+1 and ACCESS at T+2. If PREADY=1 at T+2, req_ready is high at T+3. Minimum 4 cycles per transfer; a back-to-back stream gets one transfer per 4 cycles.
- Simultaneous requests in the same cycle are resolved solely by rr_ptr order.
- Only one outstanding APB transfer ever exists.

Test Plan:
- Single write: core 1, addr 0, wdata 16'h0041, PREADY tied 1 -> PSELx at T+1, PENABLE at T+2, req_ready[1] pulse at T+3, M_PWDATA=0x0041, req_err=0.
- Round-robin: all 4 cores valid continuously from reset -> grant order 0,1,2,3,0; grant_id changes every 4 cycles; no core is served twice before the others.
- Backpressure: PREADY held 0 for 20 ACCESS cycles then 1 -> req_ready at ACCESS+21; PSELx/PENABLE stable throughout; req_err=0.
- Lock: core 2 writes 3 bytes with req_lock=1 while core 0 is valid -> core 2 receives 3 consecutive grants; core 0 is granted next after core 2 drops req_lock.
- Timeout: TIMEOUT=8, core 3 read (addr 1), PREADY stuck Z -> req_ready[3] and req_err[3] pulse after 8 ACCESS cycles; rsp_rdata unchanged; core 0 is then served.
- Async reset: reset driven low during ACCESS -> PSELx, PENABLE and busy go 0 immediately; no req_ready; after release, core 0 wins first arbitration.
